// File: rtl/cpu_slave_sm_if.sv
// CPU-side bus bundle for cpu_slave_sm: 68030 strobes in, DSACK and chip strobes out.
interface cpu_slave_sm_if;
    logic       CS_;
    logic       AS_;
    logic       DS_;
    logic       R_W;
    logic [4:0] ADDR;
    logic       BGACK_I_;
    logic       DSACK_;
    logic       DSACK_OE;
    logic [4:0] REGSEL;
    logic       REG_RD;
    logic       REG_WR;
    logic       DATA_LE;
    logic       SCSI_CS_;
    logic       IOR_;
    logic       IOW_;
    logic       BUSY;

    modport slave (
        input  CS_, AS_, DS_, R_W, ADDR, BGACK_I_,
        output DSACK_, DSACK_OE, REGSEL, REG_RD, REG_WR, DATA_LE, SCSI_CS_, IOR_, IOW_, BUSY
    );

    modport master (
        output CS_, AS_, DS_, R_W, ADDR, BGACK_I_,
        input  DSACK_, DSACK_OE, REGSEL, REG_RD, REG_WR, DATA_LE, SCSI_CS_, IOR_, IOW_, BUSY
    );
endinterface

// File: rtl/cpu_slave_sm.sv
// Target-side 68030 bus responder for the SDMAC register file and WD33C93; DSACK_ at
// edge 3+REG_WAIT (registers) or 3+SCSI_SETUP+SCSI_PULSE (SCSI); the CPU stalls on DSACK_.
module cpu_slave_sm #(
    parameter int REG_WAIT   = 1,
    parameter int SCSI_SETUP = 1,
    parameter int SCSI_PULSE = 4
) (
    input  logic           CLK,
    input  logic           aRESET_,
    cpu_slave_sm_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_SCSI,
        S_ACK,
        S_REL
    } state_t;

    localparam logic [4:0] LP_REG_LOAD = 5'(REG_WAIT - 1);
    localparam logic [4:0] LP_SETUP    = 5'(SCSI_SETUP);
    localparam logic [4:0] LP_SCSI_END = 5'(SCSI_SETUP + SCSI_PULSE);

    state_t     r_state;
    logic [1:0] r_as_sync;
    logic [1:0] r_ds_sync;
    logic [1:0] r_cs_sync;
    logic [4:0] r_cnt;
    logic       r_rw;
    logic       r_armed;
    logic       r_dsack_n;
    logic       r_dsack_oe;
    logic [4:0] r_regsel;
    logic       r_reg_rd;
    logic       r_reg_wr;
    logic       r_data_le;
    logic       r_scsi_cs_n;
    logic       r_ior_n;
    logic       r_iow_n;
    logic       r_busy;

    logic       w_sas;
    logic       w_sds;
    logic       w_scs;
    logic       w_start;
    logic [4:0] w_cnt_inc;

    assign w_sas     = r_as_sync[1];
    assign w_sds     = r_ds_sync[1];
    assign w_scs     = r_cs_sync[1];
    // r_armed guarantees AS_ was seen negated before a new cycle is accepted
    assign w_start   = r_armed & ~w_sas & ~w_sds & ~w_scs & bus.BGACK_I_;
    assign w_cnt_inc = r_cnt + 5'd1;

    always_ff @(posedge CLK or negedge aRESET_) begin
        if (!aRESET_) begin
            r_as_sync   <= 2'b11;
            r_ds_sync   <= 2'b11;
            r_cs_sync   <= 2'b11;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b1;
            r_armed     <= 1'b0;
            r_dsack_n   <= 1'b1;
            r_dsack_oe  <= 1'b0;
            r_regsel    <= '0;
            r_reg_rd    <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_data_le   <= 1'b0;
            r_scsi_cs_n <= 1'b1;
            r_ior_n     <= 1'b1;
            r_iow_n     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_as_sync <= {r_as_sync[0], bus.AS_};
            r_ds_sync <= {r_ds_sync[0], bus.DS_};
            r_cs_sync <= {r_cs_sync[0], bus.CS_};
            r_reg_wr  <= 1'b0;
            r_data_le <= 1'b0;
            if (w_sas) r_armed <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_armed  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_regsel <= bus.ADDR;
                        r_rw     <= bus.R_W;
                        if (bus.ADDR[4]) begin
                            r_state     <= S_SCSI;
                            r_cnt       <= '0;
                            r_scsi_cs_n <= 1'b0;
                            r_ior_n     <= !(bus.R_W && (LP_SETUP == 5'd0));
                            r_iow_n     <= !(!bus.R_W && (LP_SETUP == 5'd0));
                        end else begin
                            r_state   <= S_REG;
                            r_cnt     <= LP_REG_LOAD;
                            r_reg_rd  <= bus.R_W;
                            r_data_le <= !bus.R_W;
                            r_reg_wr  <= !bus.R_W && (LP_REG_LOAD == 5'd0);
                        end
                    end
                end
                S_REG: begin
                    if (w_sas) begin
                        r_state    <= S_REL;
                        r_reg_rd   <= 1'b0;
                        r_dsack_oe <= 1'b1;
                    end else if (r_cnt == 5'd0) begin
                        r_state    <= S_ACK;
                        r_dsack_n  <= 1'b0;
                        r_dsack_oe <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt - 5'd1;
                        r_reg_wr <= !r_rw && (r_cnt == 5'd1);
                    end
                end
                S_SCSI: begin
                    // abort wins over pulse completion so no DSACK_ is ever issued
                    if (w_sas) begin
                        r_state     <= S_REL;
                        r_scsi_cs_n <= 1'b1;
                        r_ior_n     <= 1'b1;
                        r_iow_n     <= 1'b1;
                        r_dsack_oe  <= 1'b1;
                    end else if (w_cnt_inc == LP_SCSI_END) begin
                        r_state    <= S_ACK;
                        r_ior_n    <= 1'b1;
                        r_iow_n    <= 1'b1;
                        r_dsack_n  <= 1'b0;
                        r_dsack_oe <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_ior_n <= !(r_rw && (w_cnt_inc >= LP_SETUP));
                        r_iow_n <= !(!r_rw && (w_cnt_inc >= LP_SETUP));
                    end
                end
                S_ACK: begin
                    if (w_sas) begin
                        r_state     <= S_REL;
                        r_dsack_n   <= 1'b1;
                        r_reg_rd    <= 1'b0;
                        r_scsi_cs_n <= 1'b1;
                    end
                end
                S_REL: begin
                    r_state    <= S_IDLE;
                    r_dsack_oe <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_dsack_n  <= 1'b1;
                    r_dsack_oe <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DSACK_   = r_dsack_n;
    assign bus.DSACK_OE = r_dsack_oe;
    assign bus.REGSEL   = r_regsel;
    assign bus.REG_RD   = r_reg_rd;
    assign bus.REG_WR   = r_reg_wr;
    assign bus.DATA_LE  = r_data_le;
    assign bus.SCSI_CS_ = r_scsi_cs_n;
    assign bus.IOR_     = r_ior_n;
    assign bus.IOW_     = r_iow_n;
    assign bus.BUSY     = r_busy;
endmodule

// File: tb/tb_cpu_slave_sm.sv
// Bench for cpu_slave_sm: two instances (default timing and REG_WAIT=3/SETUP=0/PULSE=2)
// share one stimulus and are checked every cycle against an edge-timing model.
module tb_cpu_slave_sm;
    localparam int BIG = 1000000;

    logic CLK;
    logic aRESET_;

    cpu_slave_sm_if ifa ();
    cpu_slave_sm_if ifb ();

    cpu_slave_sm dut_a (
        .CLK     (CLK),
        .aRESET_ (aRESET_),
        .bus     (ifa.slave)
    );

    cpu_slave_sm #(.REG_WAIT(3), .SCSI_SETUP(0), .SCSI_PULSE(2)) dut_b (
        .CLK     (CLK),
        .aRESET_ (aRESET_),
        .bus     (ifb.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int         cyc;
    int         n_chk;
    int         n_err;
    // current transaction as seen by the model
    int         t_id;
    int         t_e1;
    int         t_r;
    bit         t_start;
    logic [4:0] t_addr;
    bit         t_rd;
    logic [4:0] m_regsel;
    int         last_id;
    // per-instance observations for the current transaction (edge numbers relative to edge 1)
    int f_dsack[2], f_le[2], f_wr[2], f_rd[2], f_cs[2], f_stb[2];
    int c_dsack[2], c_oe[2], c_rd[2], c_wr[2], c_ior[2], c_iow[2], c_busy[2];

    // Expected {DSACK_,DSACK_OE,REGSEL,REG_RD,REG_WR,DATA_LE,SCSI_CS_,IOR_,IOW_,BUSY} after edge k
    function automatic logic [13:0] model_out(int k, int rw, int su, int pw, logic [4:0] rs);
        logic dsn, oe, rd, wr, le, csn, iorn, iown, busy;
        int   s, a, r;
        bit   ab, wrt, stb;
        dsn = 1'b1; oe = 1'b0; rd = 1'b0; wr = 1'b0; le = 1'b0;
        csn = 1'b1; iorn = 1'b1; iown = 1'b1; busy = 1'b0;
        s   = t_e1 + 2;
        r   = t_r;
        wrt = !t_rd;
        if (t_start && k >= s && k <= r) begin
            a    = t_addr[4] ? s + su + pw : s + rw;
            ab   = (r <= a);
            busy = 1'b1;
            oe   = ab ? (k == r) : (k >= a);
            dsn  = !(!ab && k >= a && k < r);
            if (!t_addr[4]) begin
                le = wrt && k == s;
                wr = wrt && k == a - 1 && k < r;
                rd = !wrt && k < r;
            end else begin
                csn  = !(k < r);
                stb  = k >= s + su && k < a && k < r;
                iorn = !(stb && !wrt);
                iown = !(stb && wrt);
            end
        end
        return {dsn, oe, rs, rd, wr, le, csn, iorn, iown, busy};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [13:0] got [2];
        logic [13:0] exp [2];
        int k;
        int rel;
        k = cyc;
        if (!aRESET_) m_regsel = '0;
        else if (t_start && k == t_e1 + 2) m_regsel = t_addr;
        got[0] = {ifa.DSACK_, ifa.DSACK_OE, ifa.REGSEL, ifa.REG_RD, ifa.REG_WR, ifa.DATA_LE,
                  ifa.SCSI_CS_, ifa.IOR_, ifa.IOW_, ifa.BUSY};
        got[1] = {ifb.DSACK_, ifb.DSACK_OE, ifb.REGSEL, ifb.REG_RD, ifb.REG_WR, ifb.DATA_LE,
                  ifb.SCSI_CS_, ifb.IOR_, ifb.IOW_, ifb.BUSY};
        exp[0] = model_out(k, 1, 1, 4, m_regsel);
        exp[1] = model_out(k, 3, 0, 2, m_regsel);
        if (t_id != last_id) begin
            for (int i = 0; i < 2; i++) begin
                f_dsack[i] = -1; f_le[i] = -1; f_wr[i] = -1; f_rd[i] = -1; f_cs[i] = -1; f_stb[i] = -1;
                c_dsack[i] = 0; c_oe[i] = 0; c_rd[i] = 0; c_wr[i] = 0; c_ior[i] = 0; c_iow[i] = 0;
                c_busy[i] = 0;
            end
            last_id = t_id;
        end
        rel = k - t_e1 + 1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL cycle dut%0d edge=%0d actual=%b expected=%b", i, k, got[i], exp[i]);
            end
            if (!got[i][13]) begin c_dsack[i]++; if (f_dsack[i] < 0) f_dsack[i] = rel; end
            if (got[i][12]) c_oe[i]++;
            if (got[i][6]) begin c_rd[i]++; if (f_rd[i] < 0) f_rd[i] = rel; end
            if (got[i][5]) begin c_wr[i]++; if (f_wr[i] < 0) f_wr[i] = rel; end
            if (got[i][4] && f_le[i] < 0) f_le[i] = rel;
            if (!got[i][3] && f_cs[i] < 0) f_cs[i] = rel;
            if (!got[i][2]) begin c_ior[i]++; if (f_stb[i] < 0) f_stb[i] = rel; end
            if (!got[i][1]) begin c_iow[i]++; if (f_stb[i] < 0) f_stb[i] = rel; end
            if (got[i][0]) c_busy[i]++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        compare_cycle();
    endtask

    task automatic set_strobes(input logic v);
        ifa.AS_ = v; ifa.DS_ = v; ifa.CS_ = v;
        ifb.AS_ = v; ifb.DS_ = v; ifb.CS_ = v;
    endtask

    task automatic set_bgack(input logic v);
        ifa.BGACK_I_ = v;
        ifb.BGACK_I_ = v;
    endtask

    task automatic begin_txn(input logic [4:0] a, input bit rd, input bit bg);
        ifa.R_W = rd; ifb.R_W = rd;
        ifa.ADDR = a; ifb.ADDR = a;
        set_bgack(bg);
        set_strobes(1'b0);
        t_id++;
        t_e1    = cyc + 1;
        t_r     = BIG;
        t_start = bg;
        t_addr  = a;
        t_rd    = rd;
    endtask

    task automatic end_txn();
        set_strobes(1'b1);
        t_r = cyc + 3;
    endtask

    task automatic wait_rel(input int e);
        while (cyc < t_e1 + e - 1) tick();
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_err = 0;
        t_id = 0; t_e1 = -10; t_r = BIG; t_start = 0; t_addr = '0; t_rd = 1;
        m_regsel = '0; last_id = -1;
        aRESET_ = 1'b0;
        set_strobes(1'b1);
        set_bgack(1'b1);
        ifa.R_W = 1'b1; ifb.R_W = 1'b1;
        ifa.ADDR = '0;  ifb.ADDR = '0;
        repeat (3) tick();
        aRESET_ = 1'b1;
        repeat (3) tick();
        chk("rst_busy", ifa.BUSY, 0);
        chk("rst_dsack", ifa.DSACK_, 1);
        chk("rst_oe", ifa.DSACK_OE, 0);
        chk("rst_regsel", ifa.REGSEL, 0);
        chk("rst_scsi_cs", ifa.SCSI_CS_, 1);
        chk("rst_ior_iow", {ifa.IOR_, ifa.IOW_}, 3);

        // register write, defaults
        begin_txn(5'h02, 1'b0, 1'b1);
        wait_rel(9);
        end_txn();
        wait_rel(11);
        chk("wr_dsack_e11", ifa.DSACK_, 0);
        wait_rel(12);
        chk("wr_dsack_e12", ifa.DSACK_, 1);
        chk("wr_oe_e12", ifa.DSACK_OE, 1);
        wait_rel(13);
        chk("wr_oe_e13", ifa.DSACK_OE, 0);
        chk("wr_le_edge", f_le[0], 3);
        chk("wr_regwr_edge", f_wr[0], 3);
        chk("wr_regwr_len", c_wr[0], 1);
        chk("wr_dsack_edge", f_dsack[0], 4);
        chk("wr_regsel", ifa.REGSEL, 2);
        chk("wr_b_regwr_edge", f_wr[1], 5);
        repeat (2) tick();

        // register read; BGACK_I_ drops mid-cycle without effect
        begin_txn(5'h05, 1'b1, 1'b1);
        wait_rel(4);
        set_bgack(1'b0);
        wait_rel(8);
        end_txn();
        wait_rel(13);
        chk("rd_b_dsack_edge", f_dsack[1], 6);
        chk("rd_b_rd_edge", f_rd[1], 3);
        chk("rd_b_rd_len", c_rd[1], 8);
        chk("rd_b_regwr", c_wr[1], 0);
        chk("rd_a_dsack_edge", f_dsack[0], 4);
        chk("rd_a_regwr", c_wr[0], 0);
        set_bgack(1'b1);
        repeat (2) tick();

        // SCSI read
        begin_txn(5'h10, 1'b1, 1'b1);
        wait_rel(10);
        end_txn();
        wait_rel(14);
        chk("scsi_cs_edge", f_cs[0], 3);
        chk("scsi_ior_edge", f_stb[0], 4);
        chk("scsi_ior_len", c_ior[0], 4);
        chk("scsi_iow_len", c_iow[0], 0);
        chk("scsi_dsack_edge", f_dsack[0], 8);
        chk("scsi_b_ior_edge", f_stb[1], 3);
        chk("scsi_b_ior_len", c_ior[1], 2);
        chk("scsi_b_dsack_edge", f_dsack[1], 5);
        repeat (2) tick();

        // DMA owns the bus: cycle must be ignored
        set_bgack(1'b0);
        tick();
        begin_txn(5'h03, 1'b0, 1'b0);
        repeat (20) tick();
        end_txn();
        repeat (4) tick();
        chk("bg_a_busy", c_busy[0], 0);
        chk("bg_b_busy", c_busy[1], 0);
        chk("bg_a_oe", c_oe[0], 0);
        chk("bg_a_le", f_le[0], -1);
        set_bgack(1'b1);
        repeat (2) tick();

        // SCSI write aborted during the second IOW_ low clock
        begin_txn(5'h11, 1'b0, 1'b1);
        wait_rel(5);
        end_txn();
        wait_rel(8);
        chk("abort_iow", ifa.IOW_, 1);
        chk("abort_scsi_cs", ifa.SCSI_CS_, 1);
        wait_rel(9);
        chk("abort_busy", ifa.BUSY, 0);
        chk("abort_dsack_cnt", c_dsack[0], 0);
        chk("abort_iow_len", c_iow[0], 4);
        chk("abort_b_dsack_cnt", c_dsack[1], 3);
        repeat (2) tick();

        // reset asserted while in ACK
        begin_txn(5'h03, 1'b0, 1'b1);
        wait_rel(7);
        chk("ack_a_dsack", ifa.DSACK_, 0);
        chk("ack_b_dsack", ifb.DSACK_, 0);
        aRESET_ = 1'b0;
        t_start = 0;
        #1;
        chk("arst_a_oe", ifa.DSACK_OE, 0);
        chk("arst_a_dsack", ifa.DSACK_, 1);
        chk("arst_b_oe", ifb.DSACK_OE, 0);
        chk("arst_b_dsack", ifb.DSACK_, 1);
        set_strobes(1'b1);
        repeat (2) tick();
        aRESET_ = 1'b1;
        repeat (3) tick();
        begin_txn(5'h01, 1'b0, 1'b1);
        wait_rel(6);
        end_txn();
        wait_rel(10);
        chk("post_rst_dsack_edge", f_dsack[0], 4);
        chk("post_rst_regwr_edge", f_wr[0], 3);
        chk("post_rst_regsel", ifa.REGSEL, 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_slave_sm.md
# cpu_slave_sm

Bus-responder state machine for CPU accesses to the SDMAC register file and the WD33C93 SCSI chip. It is the target-side counterpart of the DMA bus-master sequencer. It detects a 68030 asynchronous bus cycle addressed to the chip and issues internal register read/write strobes or a timed SCSI-chip strobe pulse. It then terminates the cycle with a 32-bit DSACK and releases the bus once AS_ negates.

## Interface
Parameters:
- REG_WAIT, 1: clocks spent in REG before acknowledge; legal range 1..15.
- SCSI_SETUP, 1: clocks from SCSI_CS_ low to IOR_/IOW_ low; legal range 0..15.
- SCSI_PULSE, 4: clocks IOR_/IOW_ held low; legal range 1..15.

Ports:
- CLK  in  1  CPU clock; all state changes on posedge.
- aRESET_  in  1  asynchronous, active-low reset.
- CS_  in  1  chip select from address glue, active low.
- AS_  in  1  68030 address strobe, active low.
- DS_  in  1  68030 data strobe, active low.
- R_W  in  1  1 = read, 0 = write.
- ADDR  in  5  longword register index (CPU A[6:2]).
- BGACK_I_  in  1  low = DMA owns the bus; new cycles are ignored.
- DSACK_  out  1  drives both DSACK1_/DSACK0_ (32-bit port), active low.
- DSACK_OE  out  1  tri-state enable for DSACK pins, active high.
- REGSEL  out  5  latched ADDR of the current cycle.
- REG_RD  out  1  internal register read enable (level).
- REG_WR  out  1  internal register write strobe (single clock).
- DATA_LE  out  1  write-data latch enable (single clock).
- SCSI_CS_  out  1  WD33C93 chip select, active low.
- IOR_  out  1  WD33C93 read strobe, active low.
- IOW_  out  1  WD33C93 write strobe, active low.
- BUSY  out  1  high whenever state is not IDLE.

## Operation
- AS_, DS_ and CS_ each pass through a 2-flop synchronizer; these flops reset to 1. R_W, ADDR and BGACK_I_ are sampled directly; they are stable while AS_ is low.
- Start condition: sAS_=0, sDS_=0, sCS_=0 and BGACK_I_=1, all in IDLE.
- States:
  - IDLE: on start, latch REGSEL←ADDR and the direction. Go to SCSI if ADDR[4]=1 (byte offset ≥0x40), otherwise to REG.
  - REG: a counter loads REG_WAIT-1 and counts down.
    - Writes: DATA_LE pulses on the entry clock; REG_WR pulses on the clock where the count = 0.
    - Reads: REG_RD is high from entry until RELEASE is entered.
    - Count = 0 → ACK.
  - SCSI: SCSI_CS_ is low from entry until RELEASE is entered. The strobe (IOR_ for reads, IOW_ for writes) is low from entry+SCSI_SETUP for SCSI_PULSE clocks. Pulse end → ACK.
  - ACK: DSACK_=0, DSACK_OE=1. On sAS_=1 → RELEASE.
  - RELEASE: DSACK_=1, DSACK_OE=1 for exactly one clock (active negation), then IDLE.
- Abort: sAS_=1 while in REG or SCSI → RELEASE on the next edge.
  - All strobes negate on that edge.
  - No DSACK_ low is issued.
  - REG_WR is not issued if its clock has not yet occurred.
- BGACK_I_ going low after the cycle has left IDLE has no effect; the cycle completes normally.
- A back-to-back cycle is recognized only after returning to IDLE with sAS_ seen high at least once.
- All outputs are registered decodes of the next state; no combinational paths from inputs to outputs.

## Timing
- Reset values: DSACK_=1, DSACK_OE=0, REGSEL=0, REG_RD=0, REG_WR=0, DATA_LE=0, SCSI_CS_=1, IOR_=1, IOW_=1, BUSY=0, state IDLE.
- Reset is asynchronous: asserting it mid-cycle forces the reset values immediately, including DSACK_OE=0 during ACK.
- Let edge 1 be the first edge sampling AS_/DS_/CS_ low:
  - Synchronized value visible at edge 2.
  - Leave IDLE at edge 3.
- Register cycle: DSACK_ low at edge 3+REG_WAIT; with defaults, edge 4. REG_WR is high between edges 2+REG_WAIT and 3+REG_WAIT.
- SCSI cycle:
  - Strobe low from edge 3+SCSI_SETUP to edge 3+SCSI_SETUP+SCSI_PULSE.
  - DSACK_ low at that last edge; with defaults, edge 8.
- Release: AS_ negation sampled at edge n gives DSACK_=1 at edge n+2 and DSACK_OE=0 at edge n+3.

## Test plan
- Write, ADDR=5'h02, defaults: DATA_LE 1 clock at edge 3; REG_WR 1 clock with REGSEL=2; DSACK_ low at edge 4; AS_ high at edge 10 → DSACK_=1 at edge 12, DSACK_OE=0 at edge 13.
- Read, ADDR=5'h05, REG_WAIT=3: REG_RD high from edge 3 through RELEASE; REG_WR never asserted; DSACK_ low at edge 6.
- SCSI read, ADDR=5'h10, defaults: SCSI_CS_ low at edge 3; IOR_ low edges 4–8; IOW_ stays 1; DSACK_ low at edge 8.
- BGACK_I_=0 with AS_/DS_/CS_ low for 20 clocks: BUSY, DSACK_OE and all strobes remain at reset values.
- Abort: SCSI write with AS_ raised during the second IOW_ low clock → IOW_ and SCSI_CS_ high within 3 edges; DSACK_ never low; BUSY=0 afterward.
- aRESET_ low while in ACK: DSACK_OE=0 and DSACK_=1 immediately. After reset release, a new write to 5'h01 completes normally with DSACK_ low at edge 4.
